// File: rtl/affine_ctrl_pkg.sv
// Shared state encoding, default widths and FP constants for the affine iteration sequencer.
// Consumed by affine_iter_ctrl and affine_watchdog.
package affine_ctrl_pkg;

    localparam int PRECISION_DEF = 32;
    localparam int CNT_W_DEF     = 16;
    localparam int TIMEOUT_DEF   = 64;

    // IEEE-754 single-precision 1.0, used by benches to build seed/offset vectors.
    localparam logic [31:0] ONE_F = 32'h3F80_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        OUTPUT = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/affine_iter_ctrl_watchdog.sv
// affine_watchdog: counts consecutive cycles in which i_run is high without i_clear and
// flags o_expire on the TIMEOUT-th such cycle. Only used when AFFINE_TIMEOUT_EN is defined.
module affine_watchdog
    import affine_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Counter starts at 0 on the first waiting cycle, so LAST marks the TIMEOUT-th cycle.
    assign o_expire = i_run && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/affine_iter_ctrl.sv
// affine_iter_ctrl: iteration sequencer around the 3-D affine transform (x' = A*x + U).
// Optional WAIT-state timeout watchdog enabled by defining AFFINE_TIMEOUT_EN.
module affine_iter_ctrl
    import affine_ctrl_pkg::*;
#(
    parameter int PRECISION = PRECISION_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [PRECISION-1:0] seed0,
    input  logic [PRECISION-1:0] seed1,
    input  logic [PRECISION-1:0] seed2,
    input  logic [CNT_W-1:0]     n_iter,
    input  logic [CNT_W-1:0]     discard,
    output logic                 at_tvalid,
    output logic [PRECISION-1:0] at_x0,
    output logic [PRECISION-1:0] at_x1,
    output logic [PRECISION-1:0] at_x2,
    input  logic                 at_valid,
    input  logic [PRECISION-1:0] at_xn0,
    input  logic [PRECISION-1:0] at_xn1,
    input  logic [PRECISION-1:0] at_xn2,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PRECISION-1:0] m_data0,
    output logic [PRECISION-1:0] m_data1,
    output logic [PRECISION-1:0] m_data2,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("affine_iter_ctrl: TIMEOUT must be at least 2");
    end

    state_t               r_state;
    state_t               w_next;

    logic [PRECISION-1:0] r_x0, r_x1, r_x2;
    logic [PRECISION-1:0] r_m0, r_m1, r_m2;
    logic [CNT_W-1:0]     r_n_iter, r_discard;
    logic [CNT_W-1:0]     r_iter_cnt, r_emit_cnt;
    logic [CNT_W-1:0]     w_emit_inc;

    logic                 w_accept;
    logic                 w_in_wait;
    logic                 w_result;
    logic                 w_warmup;
    logic                 w_handshake;
    logic                 w_expire;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_in_wait   = (r_state == WAIT);
    assign w_result    = w_in_wait && at_valid;
    assign w_warmup    = (r_iter_cnt < r_discard);
    assign w_handshake = (r_state == OUTPUT) && m_ready;
    assign w_emit_inc  = r_emit_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        at_tvalid = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (n_iter == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                at_tvalid = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (at_valid) begin
                    w_next = w_warmup ? ISSUE : OUTPUT;
                end else if (w_expire) begin
                    w_next = DONE;
                end
            end
            OUTPUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next = (w_emit_inc == r_n_iter) ? DONE : ISSUE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x0       <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_n_iter   <= '0;
            r_discard  <= '0;
            r_iter_cnt <= '0;
        end else if (w_accept) begin
            r_x0       <= seed0;
            r_x1       <= seed1;
            r_x2       <= seed2;
            r_n_iter   <= n_iter;
            r_discard  <= discard;
            r_iter_cnt <= '0;
        end else if (w_result) begin
            r_x0       <= at_xn0;
            r_x1       <= at_xn1;
            r_x2       <= at_xn2;
            r_iter_cnt <= r_iter_cnt + CNT_W'(1);
        end
    end

    // Output vector is only loaded when a post-warm-up result lands, then held through any stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m0 <= '0;
            r_m1 <= '0;
            r_m2 <= '0;
        end else if (w_result && !w_warmup) begin
            r_m0 <= at_xn0;
            r_m1 <= at_xn1;
            r_m2 <= at_xn2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_emit_cnt <= '0;
        end else if (w_accept) begin
            r_emit_cnt <= '0;
        end else if (w_handshake) begin
            r_emit_cnt <= w_emit_inc;
        end
    end

`ifdef AFFINE_TIMEOUT_EN
    logic r_error;

    affine_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_run    (w_in_wait),
        .i_clear  (at_valid),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_in_wait && w_expire) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_expire = 1'b0;
    assign error    = 1'b0;
`endif

    assign at_x0   = r_x0;
    assign at_x1   = r_x1;
    assign at_x2   = r_x2;
    assign m_data0 = r_m0;
    assign m_data1 = r_m1;
    assign m_data2 = r_m2;

endmodule

// File: tb/tb_affine_iter_ctrl.sv
// Scoreboard bench for affine_iter_ctrl with a 12-cycle behavioural transform (A=I, U=(1.0,0,0)).
module tb_affine_iter_ctrl;

    localparam int P = 32;
    localparam int C = 16;
    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [P-1:0] seed0, seed1, seed2;
    logic [C-1:0] n_iter, discard;
    logic         at_tvalid;
    logic [P-1:0] at_x0, at_x1, at_x2;
    logic         at_valid;
    logic [P-1:0] at_xn0, at_xn1, at_xn2;
    logic         m_valid;
    logic         m_ready;
    logic [P-1:0] m_data0, m_data1, m_data2;
    logic         busy, done, error;

    always #5 clk = ~clk;

    affine_iter_ctrl #(.PRECISION(P), .CNT_W(C), .TIMEOUT(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .seed0     (seed0),
        .seed1     (seed1),
        .seed2     (seed2),
        .n_iter    (n_iter),
        .discard   (discard),
        .at_tvalid (at_tvalid),
        .at_x0     (at_x0),
        .at_x1     (at_x1),
        .at_x2     (at_x2),
        .at_valid  (at_valid),
        .at_xn0    (at_xn0),
        .at_xn1    (at_xn1),
        .at_xn2    (at_xn2),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data0   (m_data0),
        .m_data1   (m_data1),
        .m_data2   (m_data2),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [95:0] exp_q[$];
    int          tv_cnt = 0;
    int          done_cnt = 0;
    int          mv_cnt = 0;
    bit          model_en = 1'b1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] f_of_int(input int n);
        int e;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = (n << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int int_of_f(input logic [31:0] b);
        int e;
        if (b == 32'h0) return 0;
        e = int'(b[30:23]) - 127;
        return (1 << e) | (int'(b[22:0]) >> (23 - e));
    endfunction

    // Behavioural transform: ignores reset, so a result in flight can land after an abort.
    initial begin
        int pend;
        logic [31:0] hx0, hx1, hx2;
        pend = 0;
        hx0 = '0; hx1 = '0; hx2 = '0;
        at_valid = 1'b0;
        at_xn0 = '0; at_xn1 = '0; at_xn2 = '0;
        forever begin
            @(negedge clk);
            at_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    at_valid = 1'b1;
                    at_xn0   = f_of_int(int_of_f(hx0) + 1);
                    at_xn1   = hx1;
                    at_xn2   = hx2;
                end
            end
            if (at_tvalid && model_en) begin
                hx0  = at_x0;
                hx1  = at_x1;
                hx2  = at_x2;
                pend = 12;
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks held data during stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (at_tvalid) tv_cnt++;
            if (done) done_cnt++;
            if (m_valid) begin
                mv_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no output",
                             {m_data0, m_data1, m_data2});
                end else begin
                    chk(m_ready ? "m_data" : "m_data_hold", {m_data0, m_data1, m_data2}, exp_q[0]);
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] s0, input int n, input int d);
        seed0   = s0;
        seed1   = '0;
        seed2   = '0;
        n_iter  = C'(n);
        discard = C'(d);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 400) begin
            step();
            k++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done: got no done after %0d cycles, expected done", name, k);
        end
        step();
        chk({name, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int t0, d0, m0, k;
        reset_n = 1'b0;
        start   = 1'b0;
        seed0 = '0; seed1 = '0; seed2 = '0;
        n_iter = '0; discard = '0;
        m_ready = 1'b1;
        step(); step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", at_tvalid, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_x", {at_x0, at_x1, at_x2}, 0);
        chk("rst_mdata", {m_data0, m_data1, m_data2}, 0);
        reset_n = 1'b1;
        step();

        // Three plain iterations from the zero seed.
        t0 = tv_cnt; d0 = done_cnt;
        exp_q.push_back({F1, 32'h0, 32'h0});
        exp_q.push_back({F2, 32'h0, 32'h0});
        exp_q.push_back({F3, 32'h0, 32'h0});
        start_run(32'h0, 3, 0);
        chk("first_tvalid", at_tvalid, 1);
        chk("first_busy", busy, 1);
        wait_done("run3");
        chk("run3_tvalids", tv_cnt - t0, 3);
        chk("run3_dones", done_cnt - d0, 1);
        chk("run3_q_empty", exp_q.size(), 0);

        // Two warm-up iterations discarded before a single emit.
        t0 = tv_cnt; d0 = done_cnt;
        exp_q.push_back({F3, 32'h0, 32'h0});
        start_run(32'h0, 1, 2);
        wait_done("disc2");
        chk("disc2_tvalids", tv_cnt - t0, 3);
        chk("disc2_dones", done_cnt - d0, 1);
        chk("disc2_q_empty", exp_q.size(), 0);

        // Backpressure on the first output.
        t0 = tv_cnt;
        m_ready = 1'b0;
        exp_q.push_back({F1, 32'h0, 32'h0});
        exp_q.push_back({F2, 32'h0, 32'h0});
        start_run(32'h0, 2, 0);
        k = 0;
        while (!m_valid && k < 100) begin
            step();
            k++;
        end
        chk("stall_mvalid_seen", m_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_tvalid", at_tvalid, 0);
            chk("stall_mvalid", m_valid, 1);
        end
        m_ready = 1'b1;
        step();
        chk("tvalid_after_hs", at_tvalid, 1);
        wait_done("stall");
        chk("stall_tvalids", tv_cnt - t0, 2);
        chk("stall_q_empty", exp_q.size(), 0);

        // n_iter == 0, with start held into the DONE cycle.
        t0 = tv_cnt; d0 = done_cnt; m0 = mv_cnt;
        seed0 = '0; n_iter = '0; discard = '0;
        start = 1'b1;
        step();
        chk("n0_done", done, 1);
        chk("n0_busy", busy, 1);
        chk("n0_tvalid", at_tvalid, 0);
        step();
        start = 1'b0;
        chk("n0_done_pulse", done, 0);
        chk("n0_idle_busy", busy, 0);
        step(); step();
        chk("n0_tvalids", tv_cnt - t0, 0);
        chk("n0_mvalids", mv_cnt - m0, 0);
        chk("n0_dones", done_cnt - d0, 1);

        // Reset while a transform is in flight; the late result must be ignored.
        t0 = tv_cnt; m0 = mv_cnt;
        start_run(F1, 1, 0);
        step(); step(); step();
        chk("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_x", {at_x0, at_x1, at_x2}, 0);
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_done", done, 0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("late_result_busy", busy, 0);
        chk("late_result_mvalids", mv_cnt - m0, 0);
        chk("late_result_tvalids", tv_cnt - t0, 1);
        exp_q.push_back({F2, 32'h0, 32'h0});
        start_run(F1, 1, 0);
        wait_done("after_rst");
        chk("after_rst_q_empty", exp_q.size(), 0);

`ifdef AFFINE_TIMEOUT_EN
        // Transform never answers: watchdog ends the run with error set.
        model_en = 1'b0;
        m0 = mv_cnt;
        start_run(32'h0, 1, 0);
        step();
        k = 0;
        while (!done && k < 200) begin
            step();
            k++;
        end
        chk("timeout_cycles", k, 64);
        chk("timeout_error", error, 1);
        step();
        chk("timeout_mvalids", mv_cnt - m0, 0);
        chk("timeout_error_sticky", error, 1);
        model_en = 1'b1;
        exp_q.push_back({F1, 32'h0, 32'h0});
        start_run(32'h0, 1, 0);
        chk("error_cleared", error, 0);
        wait_done("post_timeout");
`else
        chk("error_tied", error, 0);
`endif

        step(); step();
        chk("final_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
